// File: rtl/uno_pkg.sv
// Shared card encoding, deck draw codes and the hand-manager state type.
package uno_pkg;

    typedef struct packed {
        logic [1:0] color;
        logic [3:0] value;
    } card_t;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;
    localparam logic [1:0] BLUE   = 2'd3;

    localparam logic [3:0] VAL_0   = 4'd0;
    localparam logic [3:0] VAL_1   = 4'd1;
    localparam logic [3:0] VAL_2   = 4'd2;
    localparam logic [3:0] VAL_3   = 4'd3;
    localparam logic [3:0] VAL_4   = 4'd4;
    localparam logic [3:0] VAL_5   = 4'd5;
    localparam logic [3:0] VAL_6   = 4'd6;
    localparam logic [3:0] VAL_7   = 4'd7;
    localparam logic [3:0] VAL_8   = 4'd8;
    localparam logic [3:0] VAL_9   = 4'd9;
    localparam logic [3:0] SKIP    = 4'd10;
    localparam logic [3:0] REVERSE = 4'd11;
    localparam logic [3:0] DRAW2   = 4'd12;
    localparam logic [3:0] WILD    = 4'd13;
    localparam logic [3:0] WILD4   = 4'd14;

    localparam logic [2:0] DRAW1  = 3'b001;
    localparam logic [2:0] DRAW2C = 3'b010;
    localparam logic [2:0] DRAW4  = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_COLLECT,
        S_INSERT
    } hm_state_t;

    function automatic logic is_draw_code(input logic [2:0] code);
        return (code == DRAW1) || (code == DRAW2C) || (code == DRAW4);
    endfunction

endpackage

// File: rtl/uno_hand_manager_if.sv
// Handshake between the hand manager (master) and the deck block (slave).
interface uno_hand_manager_if;
    import uno_pkg::*;

    logic [2:0] o_draw;
    logic       o_insert;
    card_t      o_prev_card;
    logic       i_deck_done;
    logic       i_drawn;
    card_t      i_card;

    modport master (
        output o_draw,
        output o_insert,
        output o_prev_card,
        input  i_deck_done,
        input  i_drawn,
        input  i_card
    );

    modport slave (
        input  o_draw,
        input  o_insert,
        input  o_prev_card,
        output i_deck_done,
        output i_drawn,
        output i_card
    );

endinterface

// File: rtl/uno_hand_bank.sv
// One player's hand: append at the tail, delete with single-cycle shift-down,
// and two combinational read ports (display and play lookup).
module uno_hand_bank
    import uno_pkg::*;
#(
    parameter int HAND_DEPTH = 32,
    parameter int IW         = $clog2(HAND_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  card_t         wr_card,
    input  logic          del_en,
    input  logic [IW-1:0] del_idx,
    input  logic [IW-1:0] rd_idx,
    output card_t         rd_card,
    input  logic [IW-1:0] pk_idx,
    output card_t         pk_card,
    output logic [IW:0]   count,
    output logic          full
);

    localparam logic [IW:0] DEPTH = (IW + 1)'(HAND_DEPTH);
    localparam logic [IW:0] ONE   = (IW + 1)'(1);

    card_t       slots_q [HAND_DEPTH];
    card_t       slots_d [HAND_DEPTH];
    logic [IW:0] count_q;
    logic [IW:0] count_d;

    assign count   = count_q;
    assign full    = (count_q == DEPTH);
    assign rd_card = ({1'b0, rd_idx} < count_q) ? slots_q[rd_idx] : '0;
    assign pk_card = slots_q[pk_idx];

    // Slots at or above count are kept zero, so the vacated top slot is cleared on delete.
    always_comb begin
        slots_d = slots_q;
        count_d = count_q;
        if (del_en && ({1'b0, del_idx} < count_q)) begin
            for (int i = 0; i < HAND_DEPTH - 1; i++) begin
                if (i >= int'(del_idx)) begin
                    slots_d[i] = slots_q[i + 1];
                end
            end
            slots_d[HAND_DEPTH - 1] = '0;
            count_d = count_q - ONE;
        end else if (wr_en && !full) begin
            slots_d[count_q[IW-1:0]] = wr_card;
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < HAND_DEPTH; i++) begin
                slots_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            slots_q <= slots_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uno_hand_manager.sv
// Per-player hand storage and card-flow controller downstream of the deck:
// forwards draw requests, captures drawn cards, removes played cards.
module uno_hand_manager
    import uno_pkg::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int HAND_DEPTH  = 32,
    parameter int IW          = $clog2(HAND_DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [1:0]         i_player,
    input  logic [2:0]         i_draw_req,
    input  logic               i_play_req,
    input  logic [IW-1:0]      i_play_idx,
    uno_hand_manager_if.master deck,
    output card_t              o_play_card,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    input  logic [1:0]         i_rd_player,
    input  logic [IW-1:0]      i_rd_idx,
    output card_t              o_rd_card,
    output logic [IW:0]        o_rd_count
);

    hm_state_t   state_q, state_d;
    logic [1:0]  player_q, player_d;
    logic [2:0]  code_q, code_d;
    logic [2:0]  recv_q, recv_d;
    card_t       prev_card_q, prev_card_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        play_go;
    logic        player_ok;
    logic [2:0]  draw_out;
    logic        insert_out;
    logic [IW:0] sel_count;
    card_t       sel_pk;
    logic        sel_full;

    logic [IW:0] bank_count [NUM_PLAYERS];
    logic        bank_full  [NUM_PLAYERS];
    card_t       bank_rd    [NUM_PLAYERS];
    card_t       bank_pk    [NUM_PLAYERS];
    logic        bank_wr    [NUM_PLAYERS];
    logic        bank_del   [NUM_PLAYERS];

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_bank
        assign bank_wr[p]  = (state_q == S_COLLECT) && deck.i_drawn && (player_q == 2'(p));
        assign bank_del[p] = play_go && (i_player == 2'(p));

        uno_hand_bank #(
            .HAND_DEPTH (HAND_DEPTH),
            .IW         (IW)
        ) u_bank (
            .clk     (i_clk),
            .rst     (i_rst),
            .wr_en   (bank_wr[p]),
            .wr_card (deck.i_card),
            .del_en  (bank_del[p]),
            .del_idx (i_play_idx),
            .rd_idx  (i_rd_idx),
            .rd_card (bank_rd[p]),
            .pk_idx  (i_play_idx),
            .pk_card (bank_pk[p]),
            .count   (bank_count[p]),
            .full    (bank_full[p])
        );
    end

    assign player_ok = (int'(i_player) < NUM_PLAYERS);

    always_comb begin
        sel_count  = '0;
        sel_pk     = '0;
        sel_full   = 1'b0;
        o_rd_card  = '0;
        o_rd_count = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (i_player == 2'(p)) begin
                sel_count = bank_count[p];
                sel_pk    = bank_pk[p];
            end
            if (player_q == 2'(p)) begin
                sel_full = bank_full[p];
            end
            if (i_rd_player == 2'(p)) begin
                o_rd_card  = bank_rd[p];
                o_rd_count = bank_count[p];
            end
        end
    end

    // The one-hot draw code equals the card count N numerically, so code_q doubles as the target.
    always_comb begin
        state_d     = state_q;
        player_d    = player_q;
        code_d      = code_q;
        recv_d      = recv_q;
        prev_card_d = prev_card_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        play_go     = 1'b0;
        draw_out    = 3'b000;
        insert_out  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!busy_q && ((i_draw_req != 3'b000) || i_play_req)) begin
                    if (!player_ok || ((i_draw_req != 3'b000) && i_play_req)) begin
                        err_d = 1'b1;
                    end else if (i_draw_req != 3'b000) begin
                        if (is_draw_code(i_draw_req)) begin
                            player_d = i_player;
                            code_d   = i_draw_req;
                            recv_d   = 3'd0;
                            state_d  = S_REQ;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if ({1'b0, i_play_idx} < sel_count) begin
                        player_d    = i_player;
                        prev_card_d = sel_pk;
                        play_go     = 1'b1;
                        state_d     = S_INSERT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (deck.i_deck_done) begin
                    draw_out = code_q;
                    state_d  = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (deck.i_drawn) begin
                    recv_d = recv_q + 3'd1;
                    err_d  = sel_full;
                    if (recv_d == code_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_INSERT: begin
                if (deck.i_deck_done) begin
                    insert_out = 1'b1;
                    state_d    = S_IDLE;
                    done_d     = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE) || done_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            player_q    <= '0;
            code_q      <= '0;
            recv_q      <= '0;
            prev_card_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            player_q    <= player_d;
            code_q      <= code_d;
            recv_q      <= recv_d;
            prev_card_q <= prev_card_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign deck.o_draw      = draw_out;
    assign deck.o_insert    = insert_out;
    assign deck.o_prev_card = prev_card_q;
    assign o_play_card      = prev_card_q;
    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_err            = err_q;

endmodule

// File: tb/tb_uno_hand_manager.sv
// Directed bench for uno_hand_manager with a per-player hand model as scoreboard
// and an inline deck model supplying cards after each o_draw strobe.
module tb_uno_hand_manager;
    import uno_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [1:0] i_player;
    logic [2:0] i_draw_req;
    logic       i_play_req;
    logic [4:0] i_play_idx;
    logic [1:0] i_rd_player;
    logic [4:0] i_rd_idx;
    card_t      o_play_card;
    card_t      o_rd_card;
    logic       o_busy;
    logic       o_done;
    logic       o_err;
    logic [5:0] o_rd_count;

    int checks   = 0;
    int failures = 0;

    logic [5:0] model_hand [4][$];
    logic [5:0] deck_q [$];
    logic [5:0] play_sb [$];

    uno_hand_manager_if deck_if ();

    uno_hand_manager #(
        .NUM_PLAYERS (4),
        .HAND_DEPTH  (32)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_player    (i_player),
        .i_draw_req  (i_draw_req),
        .i_play_req  (i_play_req),
        .i_play_idx  (i_play_idx),
        .deck        (deck_if),
        .o_play_card (o_play_card),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .i_rd_player (i_rd_player),
        .i_rd_idx    (i_rd_idx),
        .o_rd_card   (o_rd_card),
        .o_rd_count  (o_rd_count)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_hand(input logic [1:0] p);
        int n;
        n = model_hand[p].size();
        @(negedge i_clk);
        i_rd_player = p;
        i_rd_idx    = 5'd0;
        #1 check_output("hand_count", 32'(o_rd_count), n);
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            i_rd_idx = 5'(i);
            #1 check_output("hand_slot", 32'(o_rd_card), 32'(model_hand[p][i]));
        end
        if (n < 32) begin
            @(negedge i_clk);
            i_rd_idx = 5'(n);
            #1 check_output("hand_slot_past_count", 32'(o_rd_card), 0);
        end
    endtask

    // Cards come from deck_q; lock_play fires a play request mid-collect that must be ignored.
    task automatic apply_stimulus(input logic [1:0] p, input logic [2:0] code, input int n, input bit lock_play);
        bit seen;
        bit drop;
        @(negedge i_clk);
        i_player              = p;
        i_draw_req            = code;
        deck_if.i_deck_done   = 1'b1;
        #1 check_output("draw_accept_busy", o_busy, 0);
        @(negedge i_clk);
        i_draw_req = 3'b000;
        seen = 1'b0;
        for (int w = 0; w < 8; w++) begin
            #1;
            if (deck_if.o_draw !== 3'b000) begin
                seen = 1'b1;
                break;
            end
            @(negedge i_clk);
        end
        check_output("draw_strobe_seen", seen, 1);
        check_output("draw_code", deck_if.o_draw, code);
        check_output("draw_busy", o_busy, 1);
        @(negedge i_clk);
        #1 check_output("draw_strobe_once", deck_if.o_draw, 0);
        for (int k = 0; k < n; k++) begin
            drop = (model_hand[p].size() >= 32);
            deck_if.i_drawn = 1'b1;
            deck_if.i_card  = deck_q.pop_front();
            if (!drop) model_hand[p].push_back(deck_if.i_card);
            if (lock_play && k == 0) begin
                i_play_req = 1'b1;
                i_play_idx = 5'd0;
            end
            @(negedge i_clk);
            deck_if.i_drawn = 1'b0;
            i_play_req      = 1'b0;
            #1;
            check_output("collect_err", o_err, drop);
            check_output("collect_done", o_done, (k == n - 1));
        end
        check_output("done_busy", o_busy, 1);
        @(negedge i_clk);
        #1;
        check_output("done_pulse_end", o_done, 0);
        check_output("busy_released", o_busy, 0);
    endtask

    task automatic do_play(input logic [1:0] p, input logic [4:0] idx, input int stall);
        logic [5:0] exp_card;
        @(negedge i_clk);
        deck_if.i_deck_done = (stall == 0);
        i_player   = p;
        i_play_req = 1'b1;
        i_play_idx = idx;
        play_sb.push_back(model_hand[p][idx]);
        model_hand[p].delete(int'(idx));
        #1 check_output("play_accept_busy", o_busy, 0);
        @(negedge i_clk);
        i_play_req = 1'b0;
        #1;
        for (int s = 0; s < stall; s++) begin
            check_output("insert_wait", deck_if.o_insert, 0);
            check_output("insert_wait_busy", o_busy, 1);
            @(negedge i_clk);
            if (s == stall - 1) deck_if.i_deck_done = 1'b1;
            #1;
        end
        check_output("insert_pulse", deck_if.o_insert, 1);
        exp_card = play_sb.pop_front();
        check_output("prev_card", 32'(deck_if.o_prev_card), 32'(exp_card));
        check_output("play_card", 32'(o_play_card), 32'(exp_card));
        @(negedge i_clk);
        #1;
        check_output("insert_once", deck_if.o_insert, 0);
        check_output("play_done", o_done, 1);
        check_output("play_done_busy", o_busy, 1);
        @(negedge i_clk);
        #1;
        check_output("play_done_end", o_done, 0);
        check_output("play_busy_end", o_busy, 0);
    endtask

    task automatic do_reject(input string tag, input logic [1:0] p, input logic [2:0] draw,
                             input logic play, input logic [4:0] idx);
        @(negedge i_clk);
        i_player   = p;
        i_draw_req = draw;
        i_play_req = play;
        i_play_idx = idx;
        @(negedge i_clk);
        i_draw_req = 3'b000;
        i_play_req = 1'b0;
        #1;
        check_output(tag, o_err, 1);
        check_output({tag, "_busy"}, o_busy, 0);
        @(negedge i_clk);
        #1;
        check_output({tag, "_pulse_end"}, o_err, 0);
        check_output({tag, "_no_draw"}, deck_if.o_draw, 0);
        check_output({tag, "_no_insert"}, deck_if.o_insert, 0);
    endtask

    initial begin
        i_rst               = 1'b1;
        i_player            = '0;
        i_draw_req          = '0;
        i_play_req          = 1'b0;
        i_play_idx          = '0;
        i_rd_player         = '0;
        i_rd_idx            = '0;
        deck_if.i_deck_done = 1'b1;
        deck_if.i_drawn     = 1'b0;
        deck_if.i_card      = '0;

        repeat (2) @(negedge i_clk);
        #1;
        check_output("rst_busy", o_busy, 0);
        check_output("rst_done", o_done, 0);
        check_output("rst_err", o_err, 0);
        check_output("rst_draw", deck_if.o_draw, 0);
        check_output("rst_insert", deck_if.o_insert, 0);
        check_output("rst_prev_card", 32'(deck_if.o_prev_card), 0);
        check_output("rst_play_card", 32'(o_play_card), 0);
        for (int p = 0; p < 4; p++) begin
            i_rd_player = 2'(p);
            #1 check_output("rst_count", 32'(o_rd_count), 0);
        end
        @(negedge i_clk);
        i_rst = 1'b0;

        // Reset in the middle of collecting: abort, hands cleared, stray cards ignored.
        @(negedge i_clk);
        i_player    = 2'd1;
        i_rd_player = 2'd1;
        i_draw_req  = DRAW2C;
        @(negedge i_clk);
        i_draw_req = 3'b000;
        @(negedge i_clk);
        deck_if.i_drawn = 1'b1;
        deck_if.i_card  = 6'h11;
        @(negedge i_clk);
        deck_if.i_drawn = 1'b0;
        #1 check_output("pre_rst_count", 32'(o_rd_count), 1);
        i_rst = 1'b1;
        #1;
        check_output("midrst_count", 32'(o_rd_count), 0);
        check_output("midrst_draw", deck_if.o_draw, 0);
        @(negedge i_clk);
        i_rst           = 1'b0;
        deck_if.i_drawn = 1'b1;
        deck_if.i_card  = 6'h22;
        #1 check_output("midrst_busy", o_busy, 0);
        @(negedge i_clk);
        deck_if.i_drawn = 1'b0;
        #1;
        check_output("stray_drawn_count", 32'(o_rd_count), 0);
        check_output("stray_drawn_err", o_err, 0);

        // Draw 4 to player 2, then play slot 1 with a stalled deck.
        deck_q.push_back(6'h05);
        deck_q.push_back(6'h1C);
        deck_q.push_back(6'h2D);
        deck_q.push_back(6'h3E);
        apply_stimulus(2'd2, DRAW4, 4, 1'b0);
        check_hand(2'd2);
        do_play(2'd2, 5'd1, 3);
        check_hand(2'd2);

        do_reject("err_idx_ge_count", 2'd2, 3'b000, 1'b1, 5'd3);
        do_reject("err_bad_code", 2'd2, 3'b011, 1'b0, 5'd0);
        do_reject("err_draw_and_play", 2'd2, DRAW1, 1'b1, 5'd0);
        do_reject("err_empty_hand", 2'd3, 3'b000, 1'b1, 5'd0);
        check_hand(2'd2);
        check_hand(2'd3);

        // Fill player 0 to 31 cards, then draw 2 so the second card overflows.
        for (int k = 0; k < 33; k++) begin
            deck_q.push_back({2'(k % 4), 4'(k % 15)});
        end
        for (int d = 0; d < 7; d++) begin
            apply_stimulus(2'd0, DRAW4, 4, (d == 1));
        end
        apply_stimulus(2'd0, DRAW2C, 2, 1'b0);
        apply_stimulus(2'd0, DRAW1, 1, 1'b0);
        check_hand(2'd0);
        apply_stimulus(2'd0, DRAW2C, 2, 1'b0);
        check_hand(2'd0);

        do_play(2'd0, 5'd31, 0);
        check_hand(2'd0);
        check_hand(2'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uno_hand_manager.md
# uno_hand_manager

Per-player hand storage and card-flow controller sitting directly downstream of the deck block. It forwards draw requests (1/2/4 cards) to the deck and captures each drawn card into the addressed player's hand. It removes played cards from a hand and hands the played card back to the deck as its insertion input. It also exposes a random-access read port for display and rule-checking logic.

## Interface
- NUM_PLAYERS, 4, number of hands (2..4); player index width fixed at 2 bits.
- HAND_DEPTH, 32, card slots per hand; index width `IW = $clog2(HAND_DEPTH)`.
- i_clk  in  1  clock.
- i_rst  in  1  reset: asynchronous, active-high.
- i_player  in  2  target player for i_draw_req / i_play_req.
- i_draw_req  in  3  one-cycle strobe: 001 = draw 1, 010 = draw 2, 100 = draw 4; 000 = none.
- i_play_req  in  1  one-cycle strobe: remove card i_play_idx from hand i_player.
- i_play_idx  in  IW  slot to play.
- i_deck_done  in  1  deck idle (deck o_done).
- i_drawn  in  1  deck delivers i_card this cycle (deck o_drawn).
- i_card  in  6  drawn card {color[1:0], value[3:0]}.
- o_draw  out  3  draw code to deck (deck i_draw).
- o_insert  out  1  one-cycle insert strobe to deck (deck i_insert).
- o_prev_card  out  6  played card (deck i_prev_card); holds its last value.
- o_play_card  out  6  same card as o_prev_card, for the discard/top-card register.
- o_busy  out  1  operation in progress; new requests are ignored.
- o_done  out  1  one-cycle pulse when a draw or play completes.
- o_err  out  1  one-cycle pulse on a rejected request or dropped card.
- i_rd_player  in  2  read-port player select.
- i_rd_idx  in  IW  read-port slot select.
- o_rd_card  out  6  card in the selected slot, combinational; 0 when slot ≥ count.
- o_rd_count  out  IW+1  card count of i_rd_player.

## Operation
- States: S_IDLE, S_REQ, S_COLLECT, S_INSERT.
- S_IDLE
  - A request is accepted only here with o_busy=0; the player and draw count N (1/2/4) are latched.
  - Valid one-hot i_draw_req → S_REQ.
  - i_play_req with i_play_idx < count → S_INSERT. The card is latched into o_prev_card/o_play_card.
  - Entries idx+1..count-1 shift down one slot in the same cycle, and count decrements.
- S_REQ: wait for i_deck_done=1. In that cycle, drive o_draw = latched code for exactly one cycle, then → S_COLLECT. o_draw=000 at all other times.
- S_COLLECT
  - Each cycle with i_drawn=1: write i_card to hand[p][count], count++, received++.
  - When received reaches N → S_IDLE with o_done.
- S_INSERT: wait for i_deck_done=1. In that cycle, pulse o_insert, then → S_IDLE with o_done.
- Rejected requests pulse o_err with no state change:
  - non-one-hot i_draw_req;
  - i_play_idx ≥ count (includes an empty hand);
  - i_player ≥ NUM_PLAYERS;
  - i_draw_req and i_play_req in the same cycle: both are dropped.
- Full hand: a drawn card arriving when count = HAND_DEPTH is discarded. o_err pulses, received still increments, and count saturates at HAND_DEPTH.
- Requests arriving while o_busy=1 are ignored silently (no o_err).
- i_drawn outside S_COLLECT is ignored.

## Timing
- Reset values: all counts 0, all slots 0, state S_IDLE. o_draw=000; o_insert, o_busy, o_done, o_err, o_prev_card and o_play_card all 0.
- Reset mid-operation aborts immediately to S_IDLE and clears all hands.
- o_busy is registered. It is 1 from the cycle after acceptance until the cycle o_done is asserted (inclusive); it is 0 again the cycle after.
- Play latency, with i_deck_done held at 1: accept at cycle 0, o_insert at cycle 1, o_done at cycle 2.
- Draw latency: o_draw is asserted 1 cycle after acceptance at the earliest. o_done is registered and asserts the cycle after the N-th i_drawn.
- Hand updates (shift on play, append on draw) are visible on o_rd_* the cycle after the triggering edge.
- o_rd_* are purely combinational from i_rd_* and registered state.

## Structure
- Package uno_pkg:
  - card_t (6-bit packed {color, value}).
  - color constants RED=0, YELLOW=1, GREEN=2, BLUE=3.
  - value constants 0..9, SKIP=10, REVERSE=11, DRAW2=12, WILD=13, WILD4=14.
  - draw codes DRAW1=3'b001, DRAW2C=3'b010, DRAW4=3'b100.
  - hand-manager state enum.
- Sub-module uno_hand_bank, one instance per player:
  - HAND_DEPTH-entry card_t register array plus count;
  - ports: append (wr_en, wr_card), delete (del_en, del_idx, single-cycle shift-down), combinational read;
  - outputs: count and full.
- Top level owns the FSM, the latched request, the received counter and deck handshaking.

## Test plan
- Reset: assert i_rst mid-S_COLLECT → state S_IDLE; all o_rd_count = 0; o_draw=000; o_busy=0 next cycle.
- Draw 4 to player 2 with a deck model returning 0x05, 0x1C, 0x2D, 0x3E on successive i_drawn:
  - o_draw=100 for one cycle;
  - o_done after the 4th card;
  - hand 2 slots 0..3 = 0x05, 0x1C, 0x2D, 0x3E; count = 4.
- Play idx 1 from that hand, with i_deck_done=0 for 3 cycles then 1:
  - o_prev_card = 0x1C;
  - o_insert pulses on the first i_deck_done cycle;
  - hand = 0x05, 0x2D, 0x3E; count = 3.
- Errors → o_err pulse, no state change:
  - play idx 3 when count = 3;
  - i_draw_req = 011;
  - simultaneous draw and play.
- Full hand: preload 31 cards into player 0, then draw 2 → count = 32, second card dropped with o_err, o_done still pulses.
- Busy lockout: issue i_play_req during S_COLLECT → ignored; no o_err; hands unchanged.
